// File: rtl/argmax_pkg.sv
// rtl/argmax_pkg.sv - shared state encoding and index-width helper for argmax_stream
package argmax_pkg;

    localparam logic [0:0] ST_ACC  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    typedef enum logic [0:0] {
        ACC  = ST_ACC,
        HOLD = ST_HOLD
    } argmax_state_e;

    // Index width for a frame of dim elements; never narrower than one bit.
    function automatic int argmax_idx_w(input int dim);
        return (dim > 1) ? $clog2(dim) : 1;
    endfunction

endpackage

// File: rtl/argmax_lane_reduce.sv
// rtl/argmax_lane_reduce.sv - combinational compare tree picking the best lane of one beat (runner-up under ARGMAX_STREAM_RUNNER_UP_EN)
module argmax_lane_reduce #(
    parameter int DATA_W = 32,
    parameter int LANES  = 1,
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic [LANES-1:0][DATA_W-1:0] lane_data,
    output logic [DATA_W-1:0]            best_val,
    output logic [LW-1:0]                best_lane
`ifdef ARGMAX_STREAM_RUNNER_UP_EN
    ,
    output logic                         sec_vld,
    output logic [DATA_W-1:0]            sec_val,
    output logic [LW-1:0]                sec_lane
`endif
);

    // Tree is padded to a power of two; padded leaves carry a clear valid bit.
    localparam int P = (LANES > 1) ? (1 << $clog2(LANES)) : 1;
    localparam int N = 2 * P - 1;

    logic              nv1 [N];
    logic [DATA_W-1:0] nm1 [N];
    logic [LW-1:0]     ni1 [N];
    logic              take_right;
`ifdef ARGMAX_STREAM_RUNNER_UP_EN
    logic              nv2 [N];
    logic [DATA_W-1:0] nm2 [N];
    logic [LW-1:0]     ni2 [N];
`endif

    // Heap-ordered tree: node n merges children 2n+1 (lower lanes) and 2n+2; ties keep the lower lane.
    always_comb begin
        take_right = 1'b0;
        for (int n = 0; n < N; n++) begin
            nv1[n] = 1'b0;
            nm1[n] = '0;
            ni1[n] = '0;
`ifdef ARGMAX_STREAM_RUNNER_UP_EN
            nv2[n] = 1'b0;
            nm2[n] = '0;
            ni2[n] = '0;
`endif
        end
        for (int l = 0; l < LANES; l++) begin
            nv1[P-1+l] = 1'b1;
            nm1[P-1+l] = lane_data[l];
            ni1[P-1+l] = LW'(l);
        end
        for (int n = P - 2; n >= 0; n--) begin
            take_right = nv1[2*n+2] &&
                         (!nv1[2*n+1] || ($signed(nm1[2*n+2]) > $signed(nm1[2*n+1])));
            if (take_right) begin
                nv1[n] = 1'b1;
                nm1[n] = nm1[2*n+2];
                ni1[n] = ni1[2*n+2];
            end else begin
                nv1[n] = nv1[2*n+1];
                nm1[n] = nm1[2*n+1];
                ni1[n] = ni1[2*n+1];
            end
`ifdef ARGMAX_STREAM_RUNNER_UP_EN
            if (take_right) begin
                // Left best competes with right runner-up; left wins ties.
                if (nv2[2*n+2] && (!nv1[2*n+1] || ($signed(nm2[2*n+2]) > $signed(nm1[2*n+1])))) begin
                    nv2[n] = 1'b1;
                    nm2[n] = nm2[2*n+2];
                    ni2[n] = ni2[2*n+2];
                end else begin
                    nv2[n] = nv1[2*n+1];
                    nm2[n] = nm1[2*n+1];
                    ni2[n] = ni1[2*n+1];
                end
            end else begin
                // Right best competes with left runner-up; left wins ties.
                if (nv1[2*n+2] && (!nv2[2*n+1] || ($signed(nm1[2*n+2]) > $signed(nm2[2*n+1])))) begin
                    nv2[n] = 1'b1;
                    nm2[n] = nm1[2*n+2];
                    ni2[n] = ni1[2*n+2];
                end else begin
                    nv2[n] = nv2[2*n+1];
                    nm2[n] = nm2[2*n+1];
                    ni2[n] = ni2[2*n+1];
                end
            end
`endif
        end
    end

    assign best_val  = nv1[0] ? nm1[0] : '0;
    assign best_lane = ni1[0];
`ifdef ARGMAX_STREAM_RUNNER_UP_EN
    assign sec_vld   = nv2[0];
    assign sec_val   = nm2[0];
    assign sec_lane  = ni2[0];
`endif

endmodule

// File: rtl/argmax_stream.sv
// rtl/argmax_stream.sv - streaming argmax over DIM signed scores, LANES per beat; ARGMAX_STREAM_RUNNER_UP_EN adds runner-up tracking
module argmax_stream
    import argmax_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DIM    = 10,
    parameter int LANES  = 1,
    localparam int IDX_W = argmax_idx_w(DIM)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES-1:0][DATA_W-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [IDX_W-1:0]             out_idx,
    output logic [DATA_W-1:0]            out_max,
    output logic [IDX_W-1:0]             out_idx2,
    output logic [DATA_W-1:0]            out_max2
);

    localparam int BEATS = DIM / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CW-1:0]    LAST_BEAT = CW'(BEATS - 1);
    localparam logic [IDX_W-1:0] LANES_I   = IDX_W'(LANES);

    generate
        if (DIM < 2 || (DIM % LANES) != 0) begin : g_bad_cfg
            $error("argmax_stream: DIM must be >= 2 and a multiple of LANES");
        end
    endgenerate

    argmax_state_e     state;
    logic [CW-1:0]     beat_cnt;
    logic              accept;
    logic              last_beat;
    logic              beat_wins;
    logic [DATA_W-1:0] b_val;
    logic [LW-1:0]     b_lane;
    logic [IDX_W-1:0]  base_idx;
    logic [IDX_W-1:0]  b_idx;

    assign in_ready  = (state == ACC);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;
    assign last_beat = (beat_cnt == LAST_BEAT);
    assign base_idx  = IDX_W'(beat_cnt) * LANES_I;
    assign b_idx     = base_idx + IDX_W'(b_lane);
    assign beat_wins = $signed(b_val) > $signed(out_max);

`ifdef ARGMAX_STREAM_RUNNER_UP_EN
    logic              s_vld;
    logic [DATA_W-1:0] s_val;
    logic [LW-1:0]     s_lane;
    logic [IDX_W-1:0]  s_idx;
    logic              run_vld2;

    assign s_idx = base_idx + IDX_W'(s_lane);

    argmax_lane_reduce #(
        .DATA_W (DATA_W),
        .LANES  (LANES)
    ) u_reduce (
        .lane_data (in_data),
        .best_val  (b_val),
        .best_lane (b_lane),
        .sec_vld   (s_vld),
        .sec_val   (s_val),
        .sec_lane  (s_lane)
    );
`else
    argmax_lane_reduce #(
        .DATA_W (DATA_W),
        .LANES  (LANES)
    ) u_reduce (
        .lane_data (in_data),
        .best_val  (b_val),
        .best_lane (b_lane)
    );
`endif

    // Frame sequencing: count accepted beats, present the result, wait for the consumer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ACC;
            beat_cnt <= '0;
        end else if (state == ACC) begin
            if (accept) begin
                if (last_beat) begin
                    beat_cnt <= '0;
                    state    <= HOLD;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end else if (out_ready) begin
            state <= ACC;
        end
    end

    // Running maximum: first beat loads, later beats displace only when strictly greater.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_max <= '0;
            out_idx <= '0;
        end else if (accept && (beat_cnt == '0 || beat_wins)) begin
            out_max <= b_val;
            out_idx <= b_idx;
        end
    end

`ifdef ARGMAX_STREAM_RUNNER_UP_EN
    // Running runner-up: a displaced max or a beat best that beats the old runner-up takes the slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_max2 <= '0;
            out_idx2 <= '0;
            run_vld2 <= 1'b0;
        end else if (accept) begin
            if (beat_cnt == '0) begin
                out_max2 <= s_val;
                out_idx2 <= s_idx;
                run_vld2 <= s_vld;
            end else if (beat_wins) begin
                run_vld2 <= 1'b1;
                if (s_vld && ($signed(s_val) > $signed(out_max))) begin
                    out_max2 <= s_val;
                    out_idx2 <= s_idx;
                end else begin
                    out_max2 <= out_max;
                    out_idx2 <= out_idx;
                end
            end else if (!run_vld2 || ($signed(b_val) > $signed(out_max2))) begin
                out_max2 <= b_val;
                out_idx2 <= b_idx;
                run_vld2 <= 1'b1;
            end
        end
    end
`else
    assign out_idx2 = '0;
    assign out_max2 = '0;
`endif

endmodule

// File: tb/tb_argmax_stream.sv
// tb/tb_argmax_stream.sv - randomized self-checking bench for argmax_stream (LANES=1 and LANES=2 instances)
module tb_argmax_stream;

    localparam int DW  = 32;
    localparam int DIM = 10;
    localparam int IW  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic                iv1, ir1, ov1, or1;
    logic [0:0][DW-1:0]  id1;
    logic [IW-1:0]       oi1, oi21;
    logic [DW-1:0]       om1, om21;

    logic                iv2, ir2, ov2, or2;
    logic [1:0][DW-1:0]  id2;
    logic [IW-1:0]       oi2, oi22;
    logic [DW-1:0]       om2, om22;

    argmax_stream #(.DATA_W(DW), .DIM(DIM), .LANES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1), .out_idx(oi1), .out_max(om1),
        .out_idx2(oi21), .out_max2(om21)
    );

    argmax_stream #(.DATA_W(DW), .DIM(DIM), .LANES(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
        .out_valid(ov2), .out_ready(or2), .out_idx(oi2), .out_max(om2),
        .out_idx2(oi22), .out_max2(om22)
    );

    int checks;
    int passed;
    int sel;

    logic signed [DW-1:0] frame [DIM];
    logic [IW-1:0]        exp_idx, exp_idx2;
    logic signed [DW-1:0] exp_max, exp_max2;
    logic                 pre_last_ov;

    logic          cur_ir, cur_ov;
    logic [IW-1:0] cur_oi, cur_oi2;
    logic [DW-1:0] cur_om, cur_om2;

    always_comb begin
        cur_ir  = (sel == 1) ? ir2  : ir1;
        cur_ov  = (sel == 1) ? ov2  : ov1;
        cur_oi  = (sel == 1) ? oi2  : oi1;
        cur_om  = (sel == 1) ? om2  : om1;
        cur_oi2 = (sel == 1) ? oi22 : oi21;
        cur_om2 = (sel == 1) ? om22 : om21;
    end

    // Reference: maximum is the lowest index holding the largest value; runner-up is the
    // same rule applied to every other element.
    task automatic model_frame();
        int bi;
        int ri;
        bi = 0;
        for (int i = 1; i < DIM; i++) if (frame[i] > frame[bi]) bi = i;
        ri = (bi == 0) ? 1 : 0;
        for (int i = 0; i < DIM; i++) if (i != bi && frame[i] > frame[ri]) ri = i;
        exp_idx = IW'(bi);
        exp_max = frame[bi];
`ifdef ARGMAX_STREAM_RUNNER_UP_EN
        exp_idx2 = IW'(ri);
        exp_max2 = frame[ri];
`else
        exp_idx2 = '0;
        exp_max2 = '0;
`endif
    endtask

    task automatic drive_beat(input int b, input logic v);
        if (sel == 0) begin
            iv1    = v;
            id1[0] = v ? frame[b] : $urandom;
        end else begin
            iv2    = v;
            id2[0] = v ? frame[2*b]   : $urandom;
            id2[1] = v ? frame[2*b+1] : $urandom;
        end
    endtask

    // Drives one frame from posedge+1; returns at posedge+1 after the final beat is taken.
    task automatic send_frame(input int gap_max);
        int nb;
        int n;
        nb = (sel == 1) ? DIM / 2 : DIM;
        for (int b = 0; b < nb; b++) begin
            repeat ($urandom_range(0, gap_max)) begin
                drive_beat(b, 1'b0);
                @(posedge clk); #1;
            end
            drive_beat(b, 1'b1);
            n = 0;
            while (!cur_ir && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 50) begin
                checks++;
                $display("FAIL in_ready_timeout got=0 exp=1 beat=%0d", b);
            end
            if (b == nb - 1) begin
                @(negedge clk);
                pre_last_ov = cur_ov;
            end
            @(posedge clk); #1;
        end
        drive_beat(0, 1'b0);
    endtask

    task automatic take_result();
        if (sel == 1) or2 = 1'b1; else or1 = 1'b1;
        @(posedge clk); #1;
        or1 = 1'b0;
        or2 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        iv1 = 1'b0; or1 = 1'b0; id1 = '0;
        iv2 = 1'b0; or2 = 1'b0; id2 = '0;
        sel = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (ir1 !== 1'b1) $display("FAIL reset_in_ready1 got=%0b exp=1", ir1); else passed++;
        checks++; if (ov1 !== 1'b0) $display("FAIL reset_out_valid1 got=%0b exp=0", ov1); else passed++;
        checks++; if (oi1 !== '0) $display("FAIL reset_idx1 got=%0d exp=0", oi1); else passed++;
        checks++; if (om1 !== '0) $display("FAIL reset_max1 got=%0d exp=0", om1); else passed++;
        checks++; if (oi21 !== '0 || om21 !== '0) $display("FAIL reset_second1 got=%0d/%0d exp=0/0", oi21, om21); else passed++;
        checks++; if (ir2 !== 1'b1 || ov2 !== 1'b0) $display("FAIL reset_hs2 got=%0b%0b exp=10", ir2, ov2); else passed++;
        checks++; if (oi2 !== '0 || om2 !== '0) $display("FAIL reset_out2 got=%0d/%0d exp=0/0", oi2, om2); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        sel = 0;
        frame = '{3, -5, 7, 7, 2, 0, 1, -1, 6, 4};
        model_frame();
        send_frame(0);
        checks++; if (pre_last_ov !== 1'b0) $display("FAIL basic_early_valid got=%0b exp=0", pre_last_ov); else passed++;
        checks++; if (cur_ov !== 1'b1) $display("FAIL basic_latency got=%0b exp=1", cur_ov); else passed++;
        checks++; if (cur_ir !== 1'b0) $display("FAIL basic_hold_ready got=%0b exp=0", cur_ir); else passed++;
        checks++; if (cur_oi !== 4'd2) $display("FAIL basic_idx got=%0d exp=2", cur_oi); else passed++;
        checks++; if (cur_om !== 32'd7) $display("FAIL basic_max got=%0d exp=7", $signed(cur_om)); else passed++;
        checks++; if (cur_oi2 !== exp_idx2) $display("FAIL basic_idx2 got=%0d exp=%0d", cur_oi2, exp_idx2); else passed++;
        checks++; if (cur_om2 !== exp_max2) $display("FAIL basic_max2 got=%0d exp=%0d", $signed(cur_om2), exp_max2); else passed++;
        take_result();
        checks++; if (cur_ov !== 1'b0 || cur_ir !== 1'b1) $display("FAIL basic_release got=%0b%0b exp=01", cur_ov, cur_ir); else passed++;
    endtask

    task automatic test_extremes();
        sel = 0;
        frame = '{-9, -8, -7, -6, -5, -4, -3, -2, -1, -10};
        model_frame();
        send_frame(1);
        checks++; if (cur_oi !== 4'd8) $display("FAIL neg_idx got=%0d exp=8", cur_oi); else passed++;
        checks++; if (cur_om !== 32'hFFFF_FFFF) $display("FAIL neg_max got=%0d exp=-1", $signed(cur_om)); else passed++;
        checks++; if (cur_om2 !== exp_max2) $display("FAIL neg_max2 got=%0d exp=%0d", $signed(cur_om2), exp_max2); else passed++;
        take_result();
        for (int i = 0; i < DIM; i++) frame[i] = $urandom_range(0, 200) - 100;
        frame[3] = 32'h8000_0000;
        frame[7] = 32'h7FFF_FFFF;
        model_frame();
        send_frame(0);
        checks++; if (cur_oi !== 4'd7) $display("FAIL ext_idx got=%0d exp=7", cur_oi); else passed++;
        checks++; if (cur_om !== 32'h7FFF_FFFF) $display("FAIL ext_max got=%h exp=7fffffff", cur_om); else passed++;
        checks++; if (cur_oi2 !== exp_idx2) $display("FAIL ext_idx2 got=%0d exp=%0d", cur_oi2, exp_idx2); else passed++;
        take_result();
    endtask

    task automatic test_lanes2();
        sel = 1;
        frame = '{1, 9, 9, 0, 2, 3, 4, 5, 6, 7};
        model_frame();
        send_frame(1);
        checks++; if (cur_ov !== 1'b1) $display("FAIL l2_valid got=%0b exp=1", cur_ov); else passed++;
        checks++; if (cur_oi !== 4'd1) $display("FAIL l2_idx got=%0d exp=1", cur_oi); else passed++;
        checks++; if (cur_om !== 32'd9) $display("FAIL l2_max got=%0d exp=9", $signed(cur_om)); else passed++;
        checks++; if (cur_oi2 !== exp_idx2) $display("FAIL l2_idx2 got=%0d exp=%0d", cur_oi2, exp_idx2); else passed++;
        checks++; if (cur_om2 !== exp_max2) $display("FAIL l2_max2 got=%0d exp=%0d", $signed(cur_om2), exp_max2); else passed++;
        take_result();
    endtask

    task automatic test_backpressure();
        sel = 0;
        for (int i = 0; i < DIM; i++) frame[i] = $urandom;
        model_frame();
        send_frame(0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (cur_ov !== 1'b1) $display("FAIL bp_valid c=%0d got=%0b exp=1", c, cur_ov); else passed++;
            checks++; if (cur_ir !== 1'b0) $display("FAIL bp_ready c=%0d got=%0b exp=0", c, cur_ir); else passed++;
            checks++; if (cur_oi !== exp_idx || cur_om !== exp_max) $display("FAIL bp_stable c=%0d got=%0d/%0d exp=%0d/%0d", c, cur_oi, $signed(cur_om), exp_idx, exp_max); else passed++;
        end
        @(posedge clk); #1;
        take_result();
        for (int i = 0; i < DIM; i++) frame[i] = i;
        model_frame();
        send_frame(0);
        checks++; if (cur_oi !== 4'd9 || cur_om !== 32'd9) $display("FAIL bp_second_frame got=%0d/%0d exp=9/9", cur_oi, $signed(cur_om)); else passed++;
        checks++; if (cur_oi2 !== exp_idx2) $display("FAIL bp_idx2 got=%0d exp=%0d", cur_oi2, exp_idx2); else passed++;
        take_result();
    endtask

    task automatic test_reset_midframe();
        sel = 0;
        for (int i = 0; i < DIM; i++) frame[i] = 1000 + i;
        for (int b = 0; b < 4; b++) begin
            drive_beat(b, 1'b1);
            @(posedge clk); #1;
        end
        drive_beat(0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (cur_ov !== 1'b0 || cur_ir !== 1'b1) $display("FAIL mid_rst_hs got=%0b%0b exp=01", cur_ov, cur_ir); else passed++;
        checks++; if (cur_oi !== '0 || cur_om !== '0) $display("FAIL mid_rst_out got=%0d/%0d exp=0/0", cur_oi, $signed(cur_om)); else passed++;
        checks++; if (cur_oi2 !== '0 || cur_om2 !== '0) $display("FAIL mid_rst_out2 got=%0d/%0d exp=0/0", cur_oi2, $signed(cur_om2)); else passed++;
        @(posedge clk); #1;
        frame = '{5, 4, 3, 2, 1, 0, 0, 0, 0, 0};
        model_frame();
        send_frame(0);
        checks++; if (cur_oi !== 4'd0 || cur_om !== 32'd5) $display("FAIL mid_rst_frame got=%0d/%0d exp=0/5", cur_oi, $signed(cur_om)); else passed++;
        checks++; if (cur_oi2 !== exp_idx2 || cur_om2 !== exp_max2) $display("FAIL mid_rst_second got=%0d/%0d exp=%0d/%0d", cur_oi2, $signed(cur_om2), exp_idx2, exp_max2); else passed++;
        take_result();
    endtask

    task automatic test_random();
        int bp;
        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(0, 1);
            for (int i = 0; i < DIM; i++) begin
                case (k % 3)
                    0:       frame[i] = $urandom_range(0, 6) - 3;
                    1:       frame[i] = $urandom;
                    default: frame[i] = $urandom_range(0, 2000) - 1000;
                endcase
            end
            model_frame();
            send_frame(2);
            checks++; if (cur_ov !== 1'b1) $display("FAIL rand_valid k=%0d got=%0b exp=1", k, cur_ov); else passed++;
            checks++; if (cur_oi !== exp_idx) $display("FAIL rand_idx k=%0d got=%0d exp=%0d", k, cur_oi, exp_idx); else passed++;
            checks++; if (cur_om !== exp_max) $display("FAIL rand_max k=%0d got=%0d exp=%0d", k, $signed(cur_om), exp_max); else passed++;
            checks++; if (cur_oi2 !== exp_idx2) $display("FAIL rand_idx2 k=%0d got=%0d exp=%0d", k, cur_oi2, exp_idx2); else passed++;
            checks++; if (cur_om2 !== exp_max2) $display("FAIL rand_max2 k=%0d got=%0d exp=%0d", k, $signed(cur_om2), exp_max2); else passed++;
            bp = $urandom_range(0, 3);
            repeat (bp) begin
                @(posedge clk); #1;
                checks++; if (cur_ov !== 1'b1 || cur_om !== exp_max) $display("FAIL rand_hold k=%0d got=%0b/%0d exp=1/%0d", k, cur_ov, $signed(cur_om), exp_max); else passed++;
            end
            take_result();
            checks++; if (cur_ov !== 1'b0) $display("FAIL rand_release k=%0d got=%0b exp=0", k, cur_ov); else passed++;
        end
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_basic();
        test_extremes();
        test_lanes2();
        test_backpressure();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/argmax_stream.md
# argmax_stream

- Streaming, pipelined successor to the combinational argmax.
- Accepts a vector of `DIM` signed scores as a sequence of beats, `LANES` elements per beat, under valid/ready flow control.
- Returns the index and value of the maximum once per frame over a second valid/ready channel.
- Sits between the output-layer MAC accumulator stream and the classification result register, so the full score vector never needs to be buffered.

## Interface
Parameters:
- `DATA_W`, 32: signed element width.
- `DIM`, 10: elements per frame; must be ≥ 2.
- `LANES`, 1: elements per input beat; `DIM % LANES == 0` is required, checked by elaboration assertion.
- `IDX_W`, `$clog2(DIM)`: index width (derived; not overridden).

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: block accepts a beat.
- `in_data` in `[LANES]` × `DATA_W` signed: lane `l` carries element `beat*LANES + l`.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `out_idx` out `IDX_W`: index of maximum.
- `out_max` out `DATA_W` signed: maximum value.
- `out_idx2` out `IDX_W`: runner-up index (see Configuration).
- `out_max2` out `DATA_W` signed: runner-up value.

## Operation
- States: `ACC` (accumulating a frame) and `HOLD` (result presented).
- Beat counter `beat_cnt` runs 0 .. `DIM/LANES-1`.
- `ACC`:
  - `in_ready = 1`.
  - On `in_valid && in_ready`, the lane reducer finds the beat's best element; ties go to the lowest lane.
  - Beat 0 loads the running max/index unconditionally.
  - Later beats replace the running max only if strictly greater, so on ties the lowest global index wins.
  - The index is `beat_cnt*LANES + lane`.
  - On the final beat, the running registers take the merged result, `beat_cnt` wraps to 0, and the state goes to `HOLD`.
- `HOLD`:
  - `in_ready = 0`; `out_valid = 1`; outputs are stable.
  - On `out_valid && out_ready`, the state goes to `ACC`.
- Comparisons are signed, full `DATA_W`; no saturation and no arithmetic widening.
- Reset, including mid-frame:
  - State goes to `ACC`; `beat_cnt`, `out_idx`, `out_max`, `out_idx2` and `out_max2` go to 0.
  - `out_valid` goes to 0; the partial frame is discarded.
- `in_data` is ignored when `in_valid` is low. A new frame only starts after the previous result has handshaken.

## Timing
- Latency: `out_valid` rises on the cycle after the final input beat is accepted.
- Throughput: `DIM/LANES` beats plus 1 `HOLD` cycle minimum per frame, plus any backpressure.
- `in_ready` depends only on state, never combinationally on `in_valid` or `out_ready`.
- `out_valid` and all result outputs are registered.
- Reset values: `in_ready=1` (in `ACC` after reset), `out_valid=0`, all data outputs 0.
- Gaps (`in_valid` low) mid-frame stall accumulation without loss; the counter holds.

## Configuration
- Macro: `ARGMAX_STREAM_RUNNER_UP_EN`.
- Defined:
  - The reducer and running registers also track the second-highest element under the same rules (strictly greater displaces, lowest index wins ties).
  - A value equal to the max but at a higher index becomes the runner-up.
  - `out_idx2`/`out_max2` present it in `HOLD`.
- Undefined:
  - `out_idx2` and `out_max2` are tied to 0.
  - The runner-up registers and comparators are not synthesised.
  - Primary behaviour is identical.

## Structure
- Shared package `argmax_pkg`: the `argmax_state_e` enum (`ACC`, `HOLD`), and a function computing `IDX_W`.
- Sub-module `argmax_lane_reduce`:
  - Combinational log2(`LANES`) compare tree over one beat.
  - Emits best lane value and lane index, plus the second best under the macro.
  - The top level owns the state machine, counter, running registers and the cross-beat merge.

## Test plan
- `DIM=10`, `LANES=1`, frame 3,-5,7,7,2,0,1,-1,6,4 → `out_idx=2`, `out_max=7`; `out_valid` one cycle after the 10th beat.
- All-negative frame -9,-8,-7,-6,-5,-4,-3,-2,-1,-10 → `out_idx=8`, `out_max=-1`; values `0x8000_0000` and `0x7FFF_FFFF` in one frame → max `0x7FFF_FFFF`.
- `LANES=2`, frame 1,9, 9,0, 2,3, 4,5, 6,7 → `out_idx=1`, `out_max=9` (tie across beats resolves low).
- Backpressure: `out_ready` low for 5 cycles → outputs stable, `in_ready=0` throughout; after handshake a second frame 0..9 ascending → `out_idx=9`.
- `rst` asserted after 4 of 10 beats, then a full frame 5,4,3,2,1,0,0,0,0,0 → `out_idx=0`, `out_max=5`; no stale contribution.
- Macro defined, frame 3,-5,7,7,2,0,1,-1,6,4 → `out_idx2=3`, `out_max2=7`; macro undefined → both 0.
